// File: rtl/circuit_pack_pkg.sv
// rtl/circuit_pack_pkg.sv - shared constants, types and CRC helper for the circuit frame packer
package circuit_pack_pkg;

  localparam logic [15:0] SYNC_WORD_DEFAULT = 16'hEB90;
  localparam logic [15:0] CRC_POLY          = 16'h1021;
  localparam logic [15:0] CRC_INIT          = 16'hFFFF;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_SYNC_H  = 4'd1,
    ST_SYNC_L  = 4'd2,
    ST_TYPE    = 4'd3,
    ST_LEN_H   = 4'd4,
    ST_LEN_L   = 4'd5,
    ST_PAYLOAD = 4'd6,
    ST_CRC_H   = 4'd7,
    ST_CRC_L   = 4'd8
  } state_e;

  typedef struct packed {
    logic [7:0]  ftype;
    logic [15:0] len;
  } desc_t;

  // One byte of CRC-16/CCITT-FALSE, MSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ({c[14:0], 1'b0} ^ CRC_POLY) : {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/circuit_pack_sfifo.sv
// rtl/circuit_pack_sfifo.sv - synchronous show-ahead FIFO with occupancy count
module circuit_pack_sfifo #(
  parameter int WIDTH = 24,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign dout    = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/circuit_frame_pack.sv
// rtl/circuit_frame_pack.sv - buffers parser frames and emits sync/type/len/payload/CRC output frames
module circuit_frame_pack
  import circuit_pack_pkg::*;
#(
  parameter int          DATA_DEPTH = 2048,
  parameter int          DESC_DEPTH = 4,
  parameter logic [15:0] SYNC_WORD  = SYNC_WORD_DEFAULT
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic [7:0]  frame_data,
  input  logic        frame_data_vld,
  input  logic [7:0]  frame_type,
  input  logic [15:0] frame_len,
  input  logic        frame_len_vld,
  output logic [7:0]  out_data,
  output logic        out_vld,
  output logic        out_sop,
  output logic        out_eop,
  input  logic        out_ready,
  output logic        drop_pulse,
  output logic [15:0] drop_cnt
);
  localparam int          AW      = $clog2(DATA_DEPTH);
  localparam int          DW      = $clog2(DESC_DEPTH);
  localparam logic [AW:0] DEPTH_B = (AW+1)'(DATA_DEPTH);

  logic [7:0]    mem [DATA_DEPTH];
  logic [7:0]    ram_q;
  logic [AW-1:0] frm_start, rd_ptr, rd_ptr_nxt;
  logic [AW:0]   committed;
  logic [16:0]   free_b;

  logic          in_active, ctx_act;
  logic [7:0]    in_type, ctx_type;
  logic [15:0]   in_len, ctx_len, in_cnt, ctx_cnt, cnt_nxt;
  logic          trunc, reject, wr_en, commit;
  logic [1:0]    drop_inc;
  logic [16:0]   drop_sum;

  desc_t         desc_in, desc_out;
  logic          desc_empty, desc_full;
  logic [DW:0]   desc_cnt;

  state_e        state;
  logic [15:0]   pay_cnt, crc;
  logic          adv, rel_fr, avail, load_pay;

  assign free_b = 17'(DEPTH_B - committed);

  // A frame_len_vld replaces the working context before the same-cycle byte is applied.
  always_comb begin
    ctx_act  = in_active;
    ctx_type = in_type;
    ctx_len  = in_len;
    ctx_cnt  = in_cnt;
    trunc    = 1'b0;
    reject   = 1'b0;
    if (frame_len_vld) begin
      trunc    = in_active;
      reject   = desc_full || ({1'b0, frame_len} > free_b);
      ctx_act  = !reject;
      ctx_type = frame_type;
      ctx_len  = frame_len;
      ctx_cnt  = '0;
    end
    wr_en   = ctx_act && frame_data_vld && (ctx_cnt != ctx_len);
    cnt_nxt = ctx_cnt + {15'd0, wr_en};
    commit  = ctx_act && (cnt_nxt == ctx_len);
  end

  assign desc_in  = {ctx_type, ctx_len};
  assign drop_inc = {1'b0, trunc} + {1'b0, reject};
  assign drop_sum = {1'b0, drop_cnt} + {15'd0, drop_inc};

  circuit_pack_sfifo #(.WIDTH($bits(desc_t)), .DEPTH(DESC_DEPTH)) u_desc_q (
    .clk   (sys_clk),
    .rst_n (rst_n),
    .push  (commit),
    .din   (desc_in),
    .pop   (rel_fr),
    .dout  (desc_out),
    .empty (desc_empty),
    .full  (desc_full),
    .count (desc_cnt)
  );

  // ram_q always holds mem[rd_ptr], so the next payload byte is ready one load ahead.
  always_ff @(posedge sys_clk) begin
    if (wr_en) mem[frm_start + ctx_cnt[AW-1:0]] <= frame_data;
    ram_q <= mem[rd_ptr_nxt];
  end

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      in_active  <= 1'b0;
      in_type    <= '0;
      in_len     <= '0;
      in_cnt     <= '0;
      frm_start  <= '0;
      committed  <= '0;
      drop_pulse <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      in_active  <= ctx_act && !commit;
      in_type    <= ctx_type;
      in_len     <= ctx_len;
      in_cnt     <= cnt_nxt;
      if (commit) frm_start <= frm_start + ctx_len[AW-1:0];
      committed  <= committed + (commit ? ctx_len[AW:0] : '0) - (rel_fr ? desc_out.len[AW:0] : '0);
      drop_pulse <= trunc || reject;
      drop_cnt   <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  assign adv        = !out_vld || out_ready;
  assign rel_fr     = out_vld && out_ready && (state == ST_CRC_L);
  assign avail      = (state == ST_CRC_L) ? (desc_cnt > (DW+1)'(1)) : !desc_empty;
  assign load_pay   = adv && (((state == ST_LEN_L) && (desc_out.len != 16'd0)) ||
                              ((state == ST_PAYLOAD) && (pay_cnt != 16'd0)));
  assign rd_ptr_nxt = load_pay ? rd_ptr + AW'(1) : rd_ptr;

  // state names the byte currently held in the output register.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      out_data <= '0;
      out_vld  <= 1'b0;
      out_sop  <= 1'b0;
      out_eop  <= 1'b0;
      pay_cnt  <= '0;
      crc      <= '0;
      rd_ptr   <= '0;
    end else begin
      rd_ptr <= rd_ptr_nxt;
      if (adv) begin
        out_vld <= 1'b1;
        out_sop <= 1'b0;
        out_eop <= 1'b0;
        case (state)
          ST_IDLE, ST_CRC_L: begin
            if (avail) begin
              state    <= ST_SYNC_H;
              out_data <= SYNC_WORD[15:8];
              out_sop  <= 1'b1;
              crc      <= CRC_INIT;
            end else begin
              state    <= ST_IDLE;
              out_data <= '0;
              out_vld  <= 1'b0;
            end
          end
          ST_SYNC_H: begin
            state    <= ST_SYNC_L;
            out_data <= SYNC_WORD[7:0];
          end
          ST_SYNC_L: begin
            state    <= ST_TYPE;
            out_data <= desc_out.ftype;
            crc      <= crc16_byte(crc, desc_out.ftype);
          end
          ST_TYPE: begin
            state    <= ST_LEN_H;
            out_data <= desc_out.len[15:8];
            crc      <= crc16_byte(crc, desc_out.len[15:8]);
          end
          ST_LEN_H: begin
            state    <= ST_LEN_L;
            out_data <= desc_out.len[7:0];
            crc      <= crc16_byte(crc, desc_out.len[7:0]);
          end
          ST_LEN_L, ST_PAYLOAD: begin
            if (load_pay) begin
              state    <= ST_PAYLOAD;
              out_data <= ram_q;
              crc      <= crc16_byte(crc, ram_q);
              pay_cnt  <= (state == ST_LEN_L) ? desc_out.len - 16'd1 : pay_cnt - 16'd1;
            end else begin
              state    <= ST_CRC_H;
              out_data <= crc[15:8];
            end
          end
          ST_CRC_H: begin
            state    <= ST_CRC_L;
            out_data <= crc[7:0];
            out_eop  <= 1'b1;
          end
          default: begin
            state    <= ST_IDLE;
            out_data <= '0;
            out_vld  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
